// File: rtl/i2s_read.sv
// I2S receive deframer.
// Collects 16-bit two's-complement words from a codec's serial ADC stream,
// honouring the one-bit I2S delay after each channel-select change. A new
// word is presented on data/data_ch together with a one-cycle data_en pulse.
// A channel half shorter than 16 bits is flagged by a one-cycle err pulse.
// All state updates on the falling edge of clk_n, where the codec keeps
// adcdat and adclrc stable.
module i2s_read (
    input  logic        clk_n,
    input  logic        rst,
    input  logic        adclrc,
    input  logic        adcdat,
    output logic [15:0] data,
    output logic        data_ch,
    output logic        data_en,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_lrc_prev;
    logic        r_ch;
    logic [3:0]  r_counter;
    logic [15:0] r_shreg;

    // A channel-select change seen on this edge.
    logic        w_transition;
    // The word as it stands once the current bit is shifted in.
    logic [15:0] w_word;
    // This edge carries the 16th bit of the word.
    logic        w_last;

    assign w_transition = (adclrc != r_lrc_prev);
    assign w_word       = {r_shreg[14:0], adcdat};
    assign w_last       = (r_counter == 4'd15);

    // Framing FSM, shift register and registered outputs.
    always_ff @(negedge clk_n or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lrc_prev <= 1'b0;
            r_ch       <= 1'b0;
            r_counter  <= 4'd0;
            r_shreg    <= 16'h0000;
            data       <= 16'h0000;
            data_ch    <= 1'b0;
            data_en    <= 1'b0;
            err        <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            data_en    <= 1'b0;
            err        <= 1'b0;
            r_lrc_prev <= adclrc;

            case (r_state)
                // Only learn the current channel; a word already in flight
                // at reset release is never captured.
                IDLE: begin
                    r_state <= WAIT;
                end

                // Ignore data until the channel changes; the transition
                // edge itself carries the previous word's last bit.
                WAIT: begin
                    if (w_transition) begin
                        r_state   <= SHIFT;
                        r_counter <= 4'd0;
                        r_ch      <= adclrc;
                        r_shreg   <= 16'h0000;
                    end
                end

                SHIFT: begin
                    if (w_last) begin
                        data    <= w_word;
                        data_ch <= r_ch;
                        data_en <= 1'b1;
                    end

                    if (w_transition) begin
                        // Either a tight-framed completion or a truncated
                        // word; in both cases start the next half at once.
                        if (!w_last) begin
                            err <= 1'b1;
                        end
                        r_state   <= SHIFT;
                        r_counter <= 4'd0;
                        r_ch      <= adclrc;
                        r_shreg   <= 16'h0000;
                    end else if (w_last) begin
                        // Word complete; surplus bits in this half are dropped.
                        r_state   <= WAIT;
                        r_counter <= 4'd0;
                        r_shreg   <= w_word;
                    end else begin
                        r_shreg   <= w_word;
                        r_counter <= r_counter + 4'd1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_read.sv
// Bench for i2s_read: directed channel halves are driven edge by edge; each
// half pushes its expected event (word or short-word error, with the edge
// number at which it must appear) into a queue, and an independent monitor
// pops and compares whenever data_en or err is seen.
module tb_i2s_read;

    logic        clk_n;
    logic        rst;
    logic        adclrc;
    logic        adcdat;
    logic [15:0] data;
    logic        data_ch;
    logic        data_en;
    logic        err;

    i2s_read dut (
        .clk_n   (clk_n),
        .rst     (rst),
        .adclrc  (adclrc),
        .adcdat  (adcdat),
        .data    (data),
        .data_ch (data_ch),
        .data_en (data_en),
        .err     (err)
    );

    localparam int K_NONE = 0;
    localparam int K_DATA = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        bit          is_err;
        logic [15:0] d;
        bit          ch;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_edges  = 0;
    logic        carry    = 1'b0;
    logic [15:0] hold_d   = 16'h0000;
    logic        hold_ch  = 1'b0;

    initial clk_n = 1'b1;
    always #5 clk_n = ~clk_n;

    // Count active (falling) edges; event timing is checked against this.
    always @(negedge clk_n) n_edges = n_edges + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks = n_checks + 1;
        if (act === req) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h, required %h (edge %0d)", name, act, req, n_edges);
    endtask

    // Drive one channel half of len edges. Edge 0 is the adclrc change and
    // carries the previous word's LSB when that word filled a 16-edge half.
    task automatic send_half(input bit lrc, input logic [15:0] word, input int len,
                             input int kind, input logic [15:0] prev_d, input bit prev_ch);
        int   start;
        exp_t e;
        for (int i = 0; i < len; i++) begin
            @(posedge clk_n);
            adclrc = lrc;
            if (i == 0) begin
                adcdat = carry;
                start  = n_edges + 1;
                if (kind == K_DATA) begin
                    e.is_err = 1'b0; e.d = word; e.ch = lrc; e.cyc = start + 16;
                    exp_q.push_back(e);
                end else if (kind == K_ERR) begin
                    e.is_err = 1'b1; e.d = prev_d; e.ch = prev_ch; e.cyc = start + len;
                    exp_q.push_back(e);
                end
            end else if (i <= 16) begin
                adcdat = word[16-i];
            end else begin
                adcdat = 1'b1;
            end
        end
        carry = (len == 16) ? word[0] : 1'b0;
    endtask

    // Monitor: match every output event against the queue, and check that
    // data/data_ch hold steady between completions.
    always @(posedge clk_n) begin
        exp_t e;
        if (rst) begin
            hold_d  = 16'h0000;
            hold_ch = 1'b0;
        end else begin
            if (data_en || err) begin
                if (exp_q.size() == 0) begin
                    n_checks = n_checks + 1;
                    $display("FAIL unexpected_event: got data_en=%0b err=%0b data=%h, required no event (edge %0d)",
                             data_en, err, data, n_edges);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", {30'd0, data_en, err}, e.is_err ? 32'd1 : 32'd2);
                    chk("event_edge", n_edges, e.cyc);
                    chk("event_data", {16'd0, data}, {16'd0, e.d});
                    chk("event_ch", {31'd0, data_ch}, {31'd0, e.ch});
                    if (!e.is_err) begin
                        hold_d  = e.d;
                        hold_ch = e.ch;
                    end
                end
            end
            chk("data_hold", {15'd0, data_ch, data}, {15'd0, hold_ch, hold_d});
        end
    end

    initial begin
        rst    = 1'b1;
        adclrc = 1'b1;
        adcdat = 1'b0;
        repeat (3) @(posedge clk_n);
        chk("reset_data", {16'd0, data}, 32'd0);
        chk("reset_data_ch", {31'd0, data_ch}, 32'd0);
        chk("reset_data_en", {31'd0, data_en}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);

        // Release mid-way through a right word: that partial word is dropped.
        @(posedge clk_n);
        rst = 1'b0;
        send_half(1'b1, 16'hFFFF, 20, K_NONE, 16'h0, 1'b0);

        // Nominal 32-edge halves.
        send_half(1'b0, 16'hA5C3, 32, K_DATA, 16'h0, 1'b0);
        send_half(1'b1, 16'h7FFF, 32, K_DATA, 16'h0, 1'b0);
        // Tight 16-edge halves, back to back.
        send_half(1'b0, 16'h8001, 16, K_DATA, 16'h0, 1'b0);
        send_half(1'b1, 16'h0001, 16, K_DATA, 16'h0, 1'b0);
        send_half(1'b0, 16'h1111, 32, K_DATA, 16'h0, 1'b0);
        // Short right word, then recovery on the next left word.
        send_half(1'b1, 16'hBEEF, 10, K_ERR, 16'h1111, 1'b0);
        send_half(1'b0, 16'h1234, 32, K_DATA, 16'h0, 1'b0);
        send_half(1'b1, 16'h5A5A, 32, K_DATA, 16'h0, 1'b0);

        // Asynchronous reset between edges while shifting a left word.
        send_half(1'b0, 16'hC3C3, 8, K_NONE, 16'h0, 1'b0);
        @(negedge clk_n);
        #2;
        rst = 1'b1;
        #1;
        chk("async_data", {16'd0, data}, 32'd0);
        chk("async_data_ch", {31'd0, data_ch}, 32'd0);
        chk("async_data_en", {31'd0, data_en}, 32'd0);
        chk("async_err", {31'd0, err}, 32'd0);
        repeat (3) @(posedge clk_n);
        rst = 1'b0;
        send_half(1'b0, 16'hC3C3, 6, K_NONE, 16'h0, 1'b0);
        send_half(1'b1, 16'h0F0F, 32, K_DATA, 16'h0, 1'b0);
        repeat (4) @(posedge clk_n);

        chk("events_outstanding", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2s_read.md
I2S_READ -- requirements
Module: i2s_read

Interface
REQ-001 clk_n  input  1  audio bit clock; all registers SHALL update on the falling edge of clk_n, where adcdat and adclrc are stable.
REQ-002 rst  input  1  reset, asynchronous, active-high; asserting it SHALL force the reset state immediately, with no clock edge required.
REQ-003 adclrc  input  1  channel select from codec; 0 = left, 1 = right.
REQ-004 adcdat  input  1  serial sample data from codec, MSB first, two's complement.
REQ-005 data  output  16  last completed sample word.
REQ-006 data_ch  output  1  channel of the word on data; 0 = left, 1 = right.
REQ-007 data_en  output  1  one-cycle pulse marking a new valid word on data and data_ch.
REQ-008 err  output  1  one-cycle pulse marking a short (truncated) word.

Function
REQ-009 The block SHALL have exactly three states: IDLE, WAIT and SHIFT.
REQ-010 Internal registers SHALL be: state; lrc_prev (1 bit); ch_r (1 bit); counter (4 bits); shreg (16 bits).
REQ-011 Transition definition: a transition is any clock edge where adclrc differs from lrc_prev.
- lrc_prev SHALL load adclrc on every edge in every non-reset state.
REQ-012 IDLE: the first edge after reset SHALL load lrc_prev and go to WAIT.
- No capture and no transition detection SHALL occur in IDLE.
- A word already in progress when reset is released SHALL therefore never be captured.
REQ-013 WAIT: on a transition, the block SHALL go to SHIFT with counter=0 and ch_r=adclrc.
- On any other edge, adcdat SHALL be ignored.
REQ-014 I2S one-bit delay: the MSB SHALL be sampled on the edge after the transition edge, never on the transition edge itself.
REQ-015 SHIFT sampling: on each edge, shreg SHALL load {shreg[14:0], adcdat} and counter SHALL increment by 1.
REQ-016 Word completion: on the edge where counter==15 (the 16th sampled bit), the block SHALL:
- load data={shreg[14:0], adcdat} and data_ch=ch_r;
- assert data_en for exactly that one following cycle;
- go to WAIT.
REQ-017 Bits after the 16th within the same channel half SHALL be discarded while in WAIT.
REQ-018 Simultaneous transition and completion: if a transition occurs on the same edge where counter==15, the block SHALL:
- complete the current word as in REQ-016;
- stay in SHIFT with counter=0 and ch_r=adclrc.
REQ-019 Short word: if a transition occurs in SHIFT with counter<15, the block SHALL:
- discard the partial word;
- pulse err for one cycle, without asserting data_en;
- restart in SHIFT with counter=0 and ch_r=adclrc.
- data and data_ch SHALL hold their previous values in this case.
REQ-020 Output stability: data and data_ch SHALL change only on a completion edge and SHALL hold between completions.
REQ-021 Exclusivity: data_en and err SHALL never be asserted in the same cycle.
REQ-022 Throughput: capture SHALL sustain back-to-back left/right words with no dead cycles, at a minimum of 16 clk_n periods per channel half.

Reset
REQ-023 On rst=1, the block SHALL clear all of the following and hold them while rst is high:
- state=IDLE, lrc_prev=0, ch_r=0, counter=0, shreg=0;
- data=16'h0000, data_ch=0, data_en=0, err=0.
REQ-024 Reset mid-word: reset asserted during SHIFT SHALL abort the word with no data_en or err pulse.
- After release, capture SHALL resume only at the next transition following the IDLE edge.

Verification
REQ-025 Nominal stereo: 32-clock halves, left word 16'hA5C3, right word 16'h7FFF, each MSB one edge after its adclrc change.
- Expect data_en pulse with data=16'hA5C3, data_ch=0.
- Then a pulse with data=16'h7FFF, data_ch=1, each 16 edges after its transition edge.
- Expect err=0 throughout.
REQ-026 Tight framing: 16-clock halves, words 16'h8001 and 16'h0001 back to back.
- Expect both words captured and no dead cycles (REQ-018).
- Expect data_en on consecutive 16-edge boundaries.
REQ-027 Short word: adclrc toggles after only 10 bits of a right word.
- Expect an err pulse and no data_en for that word.
- Expect data to keep the prior value.
- The next full left word 16'h1234 SHALL be captured correctly.
REQ-028 Mid-word start: reset released while adclrc=1 and right bits are mid-stream.
- Expect no output for that partial word.
- The first data_en SHALL carry the following left word.
REQ-029 Async reset: rst pulsed between clock edges during SHIFT.
- All outputs SHALL read zero immediately, without waiting for a clock edge.
- No data_en or err SHALL follow.
- Normal capture SHALL resume per REQ-024.
